// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the
// restoring divider and its subtractor.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Iteration counter must hold 0..WIDTH-1
  // with one spare bit of headroom.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/divider_sub.sv
// Plain W-bit subtractor; the MSB of diff
// is the borrow when operands are W-1 bits wide.
// Ports: a, b (operands), diff = a - b.
module divider_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff
);

  assign diff = a - b;

endmodule

// File: rtl/divider.sv
// Unsigned restoring shift-subtract divider.
// Ports: clk, reset (async low), start,
// dividend, divisor -> quotient, remainder,
// busy, done, div_by_zero.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST =
    CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // quo_q starts as the dividend, so its MSB
  // is the next dividend bit to bring in.
  assign shifted = {rem_q, quo_q[WIDTH-1]};

  divider_sub #(
    .W (WIDTH + 1)
  ) u_sub (
    .a    (shifted),
    .b    ({1'b0, dsr_q}),
    .diff (trial)
  );

  assign borrow  = trial[WIDTH];
  assign rem_nxt = borrow ? shifted[WIDTH-1:0]
                          : trial[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], ~borrow};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dz_d        = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = dividend;
            dsr_d   = divisor;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        if (cnt_q == LAST) begin
          state_d     = DONE;
          quotient_d  = quo_nxt;
          remainder_d = rem_nxt;
          dz_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider
// (WIDTH = 32).
module tb_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks;
  int failures;

  divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Returns at the negedge after the accepting edge,
  // with operands scrambled to prove they were latched.
  task automatic start_op(input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Counts busy samples starting at the current one
  // until done appears, then checks results.
  task automatic wait_done(input string tag,
                           input int exp_busy,
                           input logic [31:0] eq,
                           input logic [31:0] er);
    int nb;
    nb = 0;
    while (!done && nb < 40) begin
      if (busy) nb++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    chk({tag, "_quo"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    chk({tag, "_dz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    int seen;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    chk("rst_quo", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 2412 / 321, results hidden while running
    start_op(32'd2412, 32'd321);
    repeat (10) @(negedge clk);
    chk("mid_quo_hidden", quotient, 32'd0);
    chk("mid_rem_hidden", remainder, 32'd0);
    wait_done("d2412", 22, 32'd7, 32'd165);
    @(negedge clk);
    chk("d2412_done_1cyc", {31'd0, done}, 32'd0);
    chk("d2412_hold_quo", quotient, 32'd7);

    start_op(32'd415151, 32'd164);
    wait_done("d415151", 32, 32'd2531, 32'd67);
    start_op(32'd321, 32'd2412);
    wait_done("d321", 32, 32'd0, 32'd321);
    start_op(32'd0, 32'd1);
    wait_done("d0", 32, 32'd0, 32'd0);
    start_op(32'hFFFF_FFFF, 32'd1);
    wait_done("dmax", 32, 32'hFFFF_FFFF, 32'd0);

    // divide by zero: done one edge after accept
    start_op(32'd1, 32'd0);
    chk("dz_done", {31'd0, done}, 32'd1);
    chk("dz_busy", {31'd0, busy}, 32'd0);
    chk("dz_quo", quotient, 32'hFFFF_FFFF);
    chk("dz_rem", remainder, 32'd1);
    chk("dz_flag", {31'd0, div_by_zero}, 32'd1);
    @(negedge clk);
    chk("dz_done_1cyc", {31'd0, done}, 32'd0);
    chk("dz_flag_held", {31'd0, div_by_zero}, 32'd1);

    // start while busy is ignored
    start_op(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(negedge clk);
    start    = 1'b0;
    wait_done("d100", 27, 32'd14, 32'd2);

    // back-to-back with start held through DONE
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd6;
    wait_done("d50_5", 32, 32'd10, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_single_done", {31'd0, done}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done("d50_6", 32, 32'd8, 32'd2);

    // reset mid-division
    start_op(32'd2412, 32'd321);
    repeat (9) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_quo", quotient, 32'd0);
    chk("arst_rem", remainder, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("arst_no_done", seen, 32'd0);
    start_op(32'd2412, 32'd321);
    wait_done("d2412_again", 32, 32'd7, 32'd165);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled only in IDLE or DONE.
REQ-005 SHALL have port dividend, input, WIDTH, unsigned dividend, captured on an accepted start.
REQ-006 SHALL have port divisor, input, WIDTH, unsigned divisor, captured on an accepted start.
REQ-007 SHALL have port quotient, output, WIDTH, registered result, held until the next accepted start.
REQ-008 SHALL have port remainder, output, WIDTH, registered result, held until the next accepted start.
REQ-009 SHALL have port busy, output, 1, high while state is RUN.
REQ-010 SHALL have port done, output, 1, high for exactly one cycle when results become valid.
REQ-011 SHALL have port div_by_zero, output, 1, registered flag that the last division had divisor 0; held with the results.

Function
REQ-012 SHALL implement an unsigned restoring shift-subtract divider with states IDLE, RUN, DONE.
REQ-013 IDLE/DONE with start=1 SHALL latch the operands, clear the iteration counter, and go to RUN; divisor=0 SHALL instead go straight to DONE.
REQ-014 Each RUN cycle SHALL shift {partial remainder, quotient} left by one, bringing in the next dividend MSB.
REQ-015 Each RUN cycle SHALL form the trial difference (shifted remainder minus divisor) at WIDTH+1 bits.
REQ-016 If the trial difference has no borrow, the shifted remainder SHALL be replaced by the difference and the quotient LSB set to 1; otherwise the remainder SHALL be restored and the LSB set to 0.
REQ-017 RUN SHALL last exactly WIDTH cycles, then go to DONE.
REQ-018 Timing: start accepted at edge k; busy SHALL be high after edges k..k+WIDTH-1; done and valid results SHALL be present after edge k+WIDTH.
REQ-019 DONE SHALL last one cycle and go to IDLE unless start=1, which SHALL begin a new division (back-to-back).
REQ-020 Divide by zero SHALL set quotient to all ones and remainder to the dividend, with div_by_zero=1 and done high after edge k+1.
REQ-021 start while busy SHALL be ignored; operands and progress SHALL be unaffected.
REQ-022 Operand changes after acceptance SHALL NOT affect the running division.
REQ-023 quotient and remainder SHALL update only on the DONE transition; intermediate values SHALL NOT be visible on the outputs.

Reset
REQ-024 reset=0 SHALL immediately, regardless of clk, force state IDLE and set quotient, remainder, busy, done, div_by_zero and all internal registers to 0.
REQ-025 Reset mid-division SHALL abandon the operation; no done SHALL follow release.
REQ-026 After reset is released, the first accepted start SHALL behave per REQ-018.

Structure
REQ-027 The state encoding (IDLE, RUN, DONE) and the counter width ($clog2(WIDTH)+1) SHALL live in a shared package.
REQ-028 The trial difference SHALL use one instance of the existing subtractor block, parameterised to WIDTH+1; its MSB is the borrow.

Verification
REQ-029 2412 / 321 -> after 32 busy cycles: quotient=7, remainder=165, div_by_zero=0, done high one cycle.
REQ-030 415151 / 164 -> quotient=2531, remainder=67; 321 / 2412 -> quotient=0, remainder=321; 0 / 1 -> 0, 0.
REQ-031 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0; 1 / 0 -> done after 1 cycle, quotient=0xFFFFFFFF, remainder=1, div_by_zero=1.
REQ-032 start with 100 / 7, then start=1 with 9 / 3 in cycle 5 of RUN -> second request ignored; quotient=14, remainder=2.
REQ-033 reset=0 in cycle 10 of 2412 / 321 -> all outputs 0 immediately, no done; a fresh 2412 / 321 then completes per REQ-029.
REQ-034 start held high through DONE with 50 / 5, then 50 / 6 -> results 10 r0, then 8 r2, with a single DONE cycle between runs.
